// File: rtl/oled_pkg.sv
// Shared constants for the OLED SPI sink: panel defaults, opcodes, decoder states
// and the command argument-count table.
package oled_pkg;

  localparam int unsigned C_COLS_DEF = 96;
  localparam int unsigned C_ROWS_DEF = 64;

  localparam logic [7:0] OP_SET_COLUMN      = 8'h15;
  localparam logic [7:0] OP_SET_ROW         = 8'h75;
  localparam logic [7:0] OP_DRAW_LINE       = 8'h21;
  localparam logic [7:0] OP_DRAW_RECT       = 8'h22;
  localparam logic [7:0] OP_CONTRAST_A      = 8'h81;
  localparam logic [7:0] OP_CONTRAST_B      = 8'h82;
  localparam logic [7:0] OP_CONTRAST_C      = 8'h83;
  localparam logic [7:0] OP_MASTER_CURRENT  = 8'h87;
  localparam logic [7:0] OP_REMAP           = 8'hA0;
  localparam logic [7:0] OP_START_LINE      = 8'hA1;
  localparam logic [7:0] OP_DISPLAY_OFFSET  = 8'hA2;
  localparam logic [7:0] OP_MUX_RATIO       = 8'hA8;
  localparam logic [7:0] OP_MASTER_CONFIG   = 8'hAD;
  localparam logic [7:0] OP_POWER_SAVE      = 8'hB0;
  localparam logic [7:0] OP_PHASE_ADJUST    = 8'hB1;
  localparam logic [7:0] OP_CLOCK_DIV       = 8'hB3;
  localparam logic [7:0] OP_PRECHARGE_LEVEL = 8'hBB;
  localparam logic [7:0] OP_VCOMH           = 8'hBE;

  typedef enum logic {
    ST_IDLE,
    ST_ARGS
  } dec_state_e;

  function automatic logic [3:0] arg_count(input logic [7:0] op);
    case (op)
      OP_SET_COLUMN, OP_SET_ROW:                                return 4'd2;
      OP_CONTRAST_A, OP_CONTRAST_B, OP_CONTRAST_C,
      OP_MASTER_CURRENT, OP_REMAP, OP_START_LINE,
      OP_DISPLAY_OFFSET, OP_MUX_RATIO, OP_MASTER_CONFIG,
      OP_POWER_SAVE, OP_PHASE_ADJUST, OP_CLOCK_DIV,
      OP_PRECHARGE_LEVEL, OP_VCOMH:                             return 4'd1;
      OP_DRAW_LINE:                                             return 4'd7;
      OP_DRAW_RECT:                                             return 4'd10;
      default:                                                  return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/oled_spi_sink_if.sv
// Received-byte stream between the SPI byte receiver and the command decoder.
interface oled_spi_sink_if;
  logic       valid;
  logic [7:0] data;
  logic       dc;

  modport master (output valid, data, dc);
  modport slave  (input  valid, data, dc);
endinterface

// File: rtl/oled_spi_sink_spi_byte_rx.sv
// SPI mode-0 byte receiver: pin synchronizers, SPI clock rise detect and MSB-first shifter.
module spi_byte_rx (
  input  logic               clk,
  input  logic               rst,
  input  logic               oled_csn,
  input  logic               oled_clk,
  input  logic               oled_mosi,
  input  logic               oled_dc,
  input  logic               oled_resn,
  output logic               soft_rst,
  oled_spi_sink_if.master    rx
);

  logic [1:0] csn_sync_q, csn_sync_d;
  logic [1:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [1:0] dc_sync_q, dc_sync_d;
  logic [1:0] resn_sync_q, resn_sync_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       dc_q, dc_d;
  logic       sclk_rise;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign soft_rst  = ~resn_sync_q[1];

  always_comb begin
    csn_sync_d  = {csn_sync_q[0], oled_csn};
    sclk_sync_d = {sclk_sync_q[0], oled_clk};
    mosi_sync_d = {mosi_sync_q[0], oled_mosi};
    dc_sync_d   = {dc_sync_q[0], oled_dc};
    resn_sync_d = {resn_sync_q[0], oled_resn};
    sclk_prev_d = sclk_sync_q[1];
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    dc_d        = dc_q;
    // Deselect or panel reset discards any partial byte without emitting it.
    if (soft_rst || csn_sync_q[1]) begin
      bit_cnt_d = '0;
    end else if (sclk_rise) begin
      shift_d   = {shift_q[5:0], mosi_sync_q[1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        valid_d = 1'b1;
        data_d  = {shift_q, mosi_sync_q[1]};
        dc_d    = dc_sync_q[1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csn_sync_q  <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
      resn_sync_q <= '1;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      dc_q        <= 1'b0;
    end else begin
      csn_sync_q  <= csn_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      dc_sync_q   <= dc_sync_d;
      resn_sync_q <= resn_sync_d;
      sclk_prev_q <= sclk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      dc_q        <= dc_d;
    end
  end

  assign rx.valid = valid_q;
  assign rx.data  = data_q;
  assign rx.dc    = dc_q;

endmodule

// File: rtl/oled_spi_sink.sv
// OLED SPI sink: decodes the controller's command/argument stream and turns pixel
// bytes into framebuffer writes within the current column/row window.
module oled_spi_sink
  import oled_pkg::*;
#(
  parameter int unsigned C_cols = C_COLS_DEF,
  parameter int unsigned C_rows = C_ROWS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       oled_csn,
  input  logic       oled_clk,
  input  logic       oled_mosi,
  input  logic       oled_dc,
  input  logic       oled_resn,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       cmd_err,
  output logic       pix_we,
  output logic [6:0] pix_x,
  output logic [5:0] pix_y,
  output logic [7:0] pix_data
);

  localparam logic [6:0] COL_MAX = 7'(C_cols - 1);
  localparam logic [5:0] ROW_MAX = 6'(C_rows - 1);

  function automatic logic [6:0] clamp_col(input logic [7:0] a);
    return (a > {1'b0, COL_MAX}) ? COL_MAX : a[6:0];
  endfunction

  function automatic logic [5:0] clamp_row(input logic [7:0] a);
    return (a > {2'b00, ROW_MAX}) ? ROW_MAX : a[5:0];
  endfunction

  oled_spi_sink_if rx_if ();
  logic soft_rst;

  spi_byte_rx u_rx (
    .clk       (clk),
    .rst       (reset),
    .oled_csn  (oled_csn),
    .oled_clk  (oled_clk),
    .oled_mosi (oled_mosi),
    .oled_dc   (oled_dc),
    .oled_resn (oled_resn),
    .soft_rst  (soft_rst),
    .rx        (rx_if.master)
  );

  dec_state_e state_q, state_d;
  logic [3:0] args_left_q, args_left_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] arg_a_q, arg_a_d;
  logic [6:0] col_start_q, col_start_d, col_end_q, col_end_d, x_q, x_d;
  logic [5:0] row_start_q, row_start_d, row_end_q, row_end_d, y_q, y_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_dc_q, byte_dc_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [7:0] cmd_code_q, cmd_code_d;
  logic       cmd_err_q, cmd_err_d;
  logic       pix_we_q, pix_we_d;
  logic [6:0] pix_x_q, pix_x_d;
  logic [5:0] pix_y_q, pix_y_d;
  logic [7:0] pix_data_q, pix_data_d;
  logic [3:0] n_args;

  always_comb begin
    state_d      = state_q;
    args_left_d  = args_left_q;
    opcode_d     = opcode_q;
    arg_a_d      = arg_a_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    row_start_d  = row_start_q;
    row_end_d    = row_end_q;
    x_d          = x_q;
    y_d          = y_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_dc_d    = byte_dc_q;
    cmd_valid_d  = 1'b0;
    cmd_code_d   = cmd_code_q;
    cmd_err_d    = 1'b0;
    pix_we_d     = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_data_d   = pix_data_q;
    n_args       = arg_count(rx_if.data);

    if (soft_rst) begin
      state_d     = ST_IDLE;
      args_left_d = '0;
      col_start_d = '0;
      col_end_d   = COL_MAX;
      row_start_d = '0;
      row_end_d   = ROW_MAX;
      x_d         = '0;
      y_d         = '0;
    end else if (rx_if.valid) begin
      byte_valid_d = 1'b1;
      byte_data_d  = rx_if.data;
      byte_dc_d    = rx_if.dc;
      if (!rx_if.dc) begin
        if (state_q == ST_IDLE) begin
          opcode_d = rx_if.data;
          if (n_args == 4'd0) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = rx_if.data;
          end else begin
            state_d     = ST_ARGS;
            args_left_d = n_args;
          end
        end else begin
          args_left_d = args_left_q - 4'd1;
          // Window commands have two arguments, so the first one arrives with two left.
          if (args_left_q == 4'd2) arg_a_d = rx_if.data;
          if (args_left_q == 4'd1) begin
            state_d     = ST_IDLE;
            cmd_valid_d = 1'b1;
            cmd_code_d  = opcode_q;
            if (opcode_q == OP_SET_COLUMN) begin
              col_start_d = clamp_col(arg_a_q);
              col_end_d   = clamp_col(rx_if.data);
              x_d         = clamp_col(arg_a_q);
            end
            if (opcode_q == OP_SET_ROW) begin
              row_start_d = clamp_row(arg_a_q);
              row_end_d   = clamp_row(rx_if.data);
              y_d         = clamp_row(arg_a_q);
            end
          end
        end
      end else begin
        if (state_q == ST_ARGS) begin
          cmd_err_d   = 1'b1;
          state_d     = ST_IDLE;
          args_left_d = '0;
        end
        pix_we_d   = 1'b1;
        pix_x_d    = x_q;
        pix_y_d    = y_q;
        pix_data_d = rx_if.data;
        // Wrapping at the panel edge lets a start>end window run across the border.
        if (x_q != col_end_q) begin
          x_d = (x_q == COL_MAX) ? '0 : x_q + 7'd1;
        end else begin
          x_d = col_start_q;
          if (y_q != row_end_q) y_d = (y_q == ROW_MAX) ? '0 : y_q + 6'd1;
          else                  y_d = row_start_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      args_left_q  <= '0;
      opcode_q     <= '0;
      arg_a_q      <= '0;
      col_start_q  <= '0;
      col_end_q    <= COL_MAX;
      row_start_q  <= '0;
      row_end_q    <= ROW_MAX;
      x_q          <= '0;
      y_q          <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_dc_q    <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= '0;
      cmd_err_q    <= 1'b0;
      pix_we_q     <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      args_left_q  <= args_left_d;
      opcode_q     <= opcode_d;
      arg_a_q      <= arg_a_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      row_start_q  <= row_start_d;
      row_end_q    <= row_end_d;
      x_q          <= x_d;
      y_q          <= y_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_dc_q    <= byte_dc_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_code_q   <= cmd_code_d;
      cmd_err_q    <= cmd_err_d;
      pix_we_q     <= pix_we_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_data_q   <= pix_data_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_dc    = byte_dc_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign cmd_err    = cmd_err_q;
  assign pix_we     = pix_we_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_data   = pix_data_q;

endmodule

// File: tb/tb_oled_spi_sink.sv
// Randomized bench for oled_spi_sink with a byte-level reference model and a
// per-cycle compare process, plus the directed panel-command scenarios.
module tb_oled_spi_sink;

  localparam int COLS = 96;
  localparam int ROWS = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       oled_csn, oled_clk, oled_mosi, oled_dc, oled_resn;
  logic       byte_valid, byte_dc, cmd_valid, cmd_err, pix_we;
  logic [7:0] byte_data, cmd_code, pix_data;
  logic [6:0] pix_x;
  logic [5:0] pix_y;

  oled_spi_sink_if byte_if ();
  assign byte_if.valid = byte_valid;
  assign byte_if.data  = byte_data;
  assign byte_if.dc    = byte_dc;

  oled_spi_sink #(.C_cols(COLS), .C_rows(ROWS)) dut (
    .clk(clk), .reset(reset),
    .oled_csn(oled_csn), .oled_clk(oled_clk), .oled_mosi(oled_mosi),
    .oled_dc(oled_dc), .oled_resn(oled_resn),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_err(cmd_err),
    .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h cyc=%0d", name, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    logic [7:0] data;
    logic       dc;
    logic       cv;
    logic [7:0] code;
    logic       err;
    logic       we;
    int         px;
    int         py;
  } exp_t;

  exp_t exp_q[$];
  int   lx[$];
  int   ly[$];
  int   m_left, m_cs, m_ce, m_rs, m_re, m_x, m_y, m_errs;
  int   m_args[16];
  int   m_nseen;
  logic [7:0] m_op, m_code;

  function automatic int nargs(input logic [7:0] op);
    if (op == 8'h15 || op == 8'h75) return 2;
    if (op == 8'h21) return 7;
    if (op == 8'h22) return 10;
    if (op inside {8'h81, 8'h82, 8'h83, 8'h87, 8'hA0, 8'hA1, 8'hA2, 8'hA8,
                   8'hAD, 8'hB0, 8'hB1, 8'hB3, 8'hBB, 8'hBE}) return 1;
    return 0;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_reset();
    m_left = 0; m_cs = 0; m_ce = COLS - 1; m_rs = 0; m_re = ROWS - 1; m_x = 0; m_y = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input logic dc);
    exp_t e;
    e.due = cyc + 4; e.data = b; e.dc = dc; e.cv = 1'b0; e.err = 1'b0; e.we = 1'b0;
    e.px = 0; e.py = 0;
    if (!dc) begin
      if (m_left == 0) begin
        m_op = b; m_nseen = 0; m_left = nargs(b);
        if (m_left == 0) begin e.cv = 1'b1; m_code = b; end
      end else begin
        m_args[m_nseen] = int'(b); m_nseen++; m_left--;
        if (m_left == 0) begin
          e.cv = 1'b1; m_code = m_op;
          if (m_op == 8'h15) begin
            m_cs = imin(m_args[0], COLS - 1); m_ce = imin(m_args[1], COLS - 1); m_x = m_cs;
          end
          if (m_op == 8'h75) begin
            m_rs = imin(m_args[0], ROWS - 1); m_re = imin(m_args[1], ROWS - 1); m_y = m_rs;
          end
        end
      end
    end else begin
      if (m_left != 0) begin e.err = 1'b1; m_left = 0; m_errs++; end
      e.we = 1'b1; e.px = m_x; e.py = m_y;
      lx.push_back(m_x); ly.push_back(m_y);
      if (m_x == m_ce) begin
        m_x = m_cs;
        m_y = (m_y == m_re) ? m_rs : (m_y + 1) % ROWS;
      end else begin
        m_x = (m_x + 1) % COLS;
      end
    end
    e.code = m_code;
    exp_q.push_back(e);
  endfunction

  // ---------------- compare process ----------------
  bit   chk_en = 1'b0;
  int   bv_count = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        cur = exp_q.pop_front();
        chk("byte_valid", 32'(byte_valid), 32'd1);
        chk("byte_data", 32'(byte_data), 32'(cur.data));
        chk("byte_dc", 32'(byte_dc), 32'(cur.dc));
        chk("cmd_valid", 32'(cmd_valid), 32'(cur.cv));
        chk("cmd_code", 32'(cmd_code), 32'(cur.code));
        chk("cmd_err", 32'(cmd_err), 32'(cur.err));
        chk("pix_we", 32'(pix_we), 32'(cur.we));
        if (cur.we) begin
          chk("pix_x", 32'(pix_x), 32'(cur.px));
          chk("pix_y", 32'(pix_y), 32'(cur.py));
          chk("pix_data", 32'(pix_data), 32'(cur.data));
        end
      end else begin
        chk("idle_strobes", 32'({byte_valid, cmd_valid, cmd_err, pix_we}), 32'd0);
      end
      if (byte_valid) bv_count++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
    oled_dc = dc;
    for (int i = 0; i < nbits; i++) begin
      oled_clk  = 1'b0;
      oled_mosi = b[7-i];
      repeat (3) @(negedge clk);
      oled_clk = 1'b1;
      if (i == 7) model_byte(b, dc);
      repeat (3) @(negedge clk);
    end
    oled_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, dc, 8);
  endtask

  task automatic csn_gap();
    oled_csn = 1'b1;
    repeat (4) @(negedge clk);
    oled_csn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic soft_reset();
    repeat (2) @(negedge clk);
    oled_resn = 1'b0;
    repeat (4) @(negedge clk);
    oled_resn = 1'b1;
    repeat (4) @(negedge clk);
    model_reset();
  endtask

  logic [7:0] ops [12] = '{8'h15, 8'h75, 8'h81, 8'hA0, 8'hBE, 8'h21, 8'h22,
                           8'hA5, 8'hAF, 8'h2E, 8'hB3, 8'h00};
  int ex[7] = '{16, 17, 18, 16, 17, 18, 16};
  int ey[7] = '{5, 5, 5, 6, 6, 6, 5};
  int base, errs0, r;

  initial begin
    reset = 1'b1; oled_csn = 1'b1; oled_clk = 1'b0; oled_mosi = 1'b0;
    oled_dc = 1'b0; oled_resn = 1'b1;
    m_code = 8'h00; m_op = 8'h00; m_errs = 0; m_nseen = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_strobes", 32'({byte_valid, cmd_valid, cmd_err, pix_we}), 32'd0);
    chk("rst_byte_data", 32'(byte_data), 32'd0);
    chk("rst_byte_dc", 32'(byte_dc), 32'd0);
    chk("rst_cmd_code", 32'(cmd_code), 32'd0);
    chk("rst_pix", 32'({pix_x, pix_y, pix_data}), 32'd0);
    chk_en = 1'b1;
    oled_csn = 1'b0;
    repeat (3) @(negedge clk);

    // Single no-argument command
    send_byte(8'hA5, 1'b0);
    chk("model_code_a5", 32'(m_code), 32'hA5);

    // Column/row window and pixel walk
    lx.delete(); ly.delete();
    send_byte(8'h15, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h12, 1'b0);
    send_byte(8'h75, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h06, 1'b0);
    for (int i = 0; i < 7; i++) send_byte(8'h1E, 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk("model_walk_x", 32'(lx[i]), 32'(ex[i]));
      chk("model_walk_y", 32'(ly[i]), 32'(ey[i]));
    end

    // Column arguments clamp to the last column
    send_byte(8'h15, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0);
    send_byte(8'h44, 1'b1);
    chk("model_clamp_x", 32'(lx[$]), 32'd95);

    // Data byte interrupts a pending argument
    soft_reset();
    errs0 = m_errs;
    send_byte(8'h81, 1'b0);
    send_byte(8'h33, 1'b1);
    chk("model_err_count", 32'(m_errs - errs0), 32'd1);
    chk("model_err_xy", 32'({lx[$], ly[$]}), 32'd0);

    // Partial byte discarded by deselect
    repeat (6) @(negedge clk);
    base = bv_count;
    send_bits(8'hFF, 1'b0, 5);
    csn_gap();
    send_byte(8'h3C, 1'b0);
    repeat (6) @(negedge clk);
    chk("partial_one_byte", 32'(bv_count - base), 32'd1);

    // Panel reset in the middle of a long command
    send_byte(8'h15, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h30, 1'b0);
    send_byte(8'h22, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    soft_reset();
    chk("model_idle_after_resn", 32'(m_left), 32'd0);
    send_byte(8'h5A, 1'b1);
    chk("model_resn_xy", 32'({lx[$], ly[$]}), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 220; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) soft_reset();
      else if (r < 9) begin
        send_bits(8'($urandom), 1'($urandom), $urandom_range(1, 7));
        csn_gap();
      end else if (r < 16) csn_gap();
      else if (r < 40) send_byte(ops[$urandom_range(0, 11)], 1'b0);
      else if (r < 58) send_byte(8'($urandom), 1'b0);
      else send_byte(8'($urandom), 1'b1);
    end

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
